// File: rtl/imm_gen_stage_pkg.sv
// ----------------------------------------------------------------------------
// imm_gen_stage_pkg : opcode constants and format encodings for imm_gen_stage
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package imm_gen_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_OP_32    = 7'b0111011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

endpackage

`default_nettype wire

// File: rtl/imm_gen_stage_if.sv
// ----------------------------------------------------------------------------
// imm_gen_stage_if : upstream/downstream valid-ready bundle of imm_gen_stage
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_instruction;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_imm;
  logic [2:0]       o_fmt;
  logic             o_illegal;
  logic [TAG_W-1:0] o_tag;

  // Environment side: feeds instructions and consumes results.
  modport master (
    output i_valid, i_instruction, i_tag, i_ready,
    input  o_ready, o_valid, o_imm, o_fmt, o_illegal, o_tag
  );

  // Stage side.
  modport slave (
    input  i_valid, i_instruction, i_tag, i_ready,
    output o_ready, o_valid, o_imm, o_fmt, o_illegal, o_tag
  );
endinterface

`default_nettype wire

// File: rtl/imm_gen_stage_imm_decode.sv
// ----------------------------------------------------------------------------
// imm_decode : combinational RV32I/RV64I format decode and immediate extraction
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  wire logic [31:0]     i_instruction,
  output logic      [XLEN-1:0] o_imm,
  output fmt_e                 o_fmt,
  output logic                 o_illegal
);

  logic [31:0] w_imm32;
  logic [31:0] w_inst;

  assign w_inst = i_instruction;

  // Every listed opcode ends in 2'b11, so compressed encodings fall to default.
  always_comb begin
    w_imm32   = '0;
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    case (w_inst[6:0])
      OP_LOAD, OP_OP_IMM, OP_JALR, OP_SYSTEM, OP_MISC_MEM: begin
        o_fmt   = FMT_I;
        w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          o_fmt   = FMT_I;
          w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_STORE: begin
        o_fmt   = FMT_S;
        w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      end
      OP_BRANCH: begin
        o_fmt   = FMT_B;
        w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                   w_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        o_fmt   = FMT_U;
        w_imm32 = {w_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        o_fmt   = FMT_J;
        w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                   w_inst[30:21], 1'b0};
      end
      OP_OP: begin
        o_fmt = FMT_NONE;
      end
      OP_OP_32: begin
        o_illegal = (XLEN != 64);
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  generate
    if (XLEN == 32) begin : g_x32
      assign o_imm = w_imm32;
    end else begin : g_xwide
      assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/imm_gen_stage.sv
// ----------------------------------------------------------------------------
// imm_gen_stage : registered immediate-generation stage with a 2-entry skid buffer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 32
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst_n,
  input  wire logic           i_flush,
  imm_gen_stage_if.slave      bus
);

  logic [XLEN-1:0]  w_dec_imm;
  fmt_e             w_dec_fmt;
  logic             w_dec_illegal;

  logic             out_valid_q,   out_valid_d;
  logic [XLEN-1:0]  out_imm_q,     out_imm_d;
  fmt_e             out_fmt_q,     out_fmt_d;
  logic             out_illegal_q, out_illegal_d;
  logic [TAG_W-1:0] out_tag_q,     out_tag_d;

  logic             skid_valid_q,   skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,     skid_imm_d;
  fmt_e             skid_fmt_q,     skid_fmt_d;
  logic             skid_illegal_q, skid_illegal_d;
  logic [TAG_W-1:0] skid_tag_q,     skid_tag_d;

  logic             w_accept;
  logic             w_out_free;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instruction (bus.i_instruction),
    .o_imm         (w_dec_imm),
    .o_fmt         (w_dec_fmt),
    .o_illegal     (w_dec_illegal)
  );

  assign w_accept   = bus.i_valid & ~skid_valid_q;
  assign w_out_free = ~out_valid_q | bus.i_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_imm_d      = out_imm_q;
    out_fmt_d      = out_fmt_q;
    out_illegal_d  = out_illegal_q;
    out_tag_d      = out_tag_q;
    skid_valid_d   = skid_valid_q;
    skid_imm_d     = skid_imm_q;
    skid_fmt_d     = skid_fmt_q;
    skid_illegal_d = skid_illegal_q;
    skid_tag_d     = skid_tag_q;

    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_out_free) begin
      // Skid contents are older than anything upstream; drain them first.
      if (skid_valid_q) begin
        out_valid_d   = 1'b1;
        out_imm_d     = skid_imm_q;
        out_fmt_d     = skid_fmt_q;
        out_illegal_d = skid_illegal_q;
        out_tag_d     = skid_tag_q;
        skid_valid_d  = 1'b0;
      end else if (w_accept) begin
        out_valid_d   = 1'b1;
        out_imm_d     = w_dec_imm;
        out_fmt_d     = w_dec_fmt;
        out_illegal_d = w_dec_illegal;
        out_tag_d     = bus.i_tag;
      end else begin
        out_valid_d   = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d   = 1'b1;
      skid_imm_d     = w_dec_imm;
      skid_fmt_d     = w_dec_fmt;
      skid_illegal_d = w_dec_illegal;
      skid_tag_d     = bus.i_tag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_fmt_q      <= FMT_NONE;
      out_illegal_q  <= 1'b0;
      out_tag_q      <= '0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_NONE;
      skid_illegal_q <= 1'b0;
      skid_tag_q     <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_imm_q      <= out_imm_d;
      out_fmt_q      <= out_fmt_d;
      out_illegal_q  <= out_illegal_d;
      out_tag_q      <= out_tag_d;
      skid_valid_q   <= skid_valid_d;
      skid_imm_q     <= skid_imm_d;
      skid_fmt_q     <= skid_fmt_d;
      skid_illegal_q <= skid_illegal_d;
      skid_tag_q     <= skid_tag_d;
    end
  end

  assign bus.o_ready   = ~skid_valid_q;
  assign bus.o_valid   = out_valid_q;
  assign bus.o_imm     = out_imm_q;
  assign bus.o_fmt     = out_fmt_q;
  assign bus.o_illegal = out_illegal_q;
  assign bus.o_tag     = out_tag_q;

endmodule

`default_nettype wire
